// File: rtl/axi3_nport_bridge_pkg.sv
// axi3_nport_bridge_pkg: AXI encodings and FSM state types shared by the bridge.
package axi3_nport_bridge_pkg;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;
endpackage

// File: rtl/axi3_nport_bridge_if.sv
// axi3_nport_bridge_if: AXI3 master bus and client-side request/response bundles.
interface axi3_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 4,
  parameter int LEN_W = 8
);
  logic [ID_W-1:0] arid, rid, awid, wid, bid;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [LEN_W-1:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0] arcache, awcache;
  logic [DATA_W-1:0] rdata, wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic arvalid, arready, rvalid, rready, rlast;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input wid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
endinterface

interface nport_client_if #(
  parameter int N_RD = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W = 8
);
  logic [N_RD-1:0] rd_req_valid, rd_req_ready, rd_resp_valid, rd_resp_ready;
  logic [N_RD*ADDR_W-1:0] rd_req_addr;
  logic [N_RD*LEN_W-1:0] rd_req_len;
  logic [N_RD*3-1:0] rd_req_size;
  logic [DATA_W-1:0] rd_resp_data, wr_data;
  logic rd_resp_last;
  logic wr_req_valid, wr_req_ready, wr_data_valid, wr_data_ready, wr_done;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [LEN_W-1:0] wr_req_len;
  logic [2:0] wr_req_size;
  logic [DATA_W/8-1:0] wr_strb;
  logic [1:0] wr_resp;
  modport master (
    output rd_req_valid, rd_req_addr, rd_req_len, rd_req_size, rd_resp_ready,
    output wr_req_valid, wr_req_addr, wr_req_len, wr_req_size, wr_data_valid, wr_data, wr_strb,
    input rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_last,
    input wr_req_ready, wr_data_ready, wr_done, wr_resp
  );
  modport slave (
    input rd_req_valid, rd_req_addr, rd_req_len, rd_req_size, rd_resp_ready,
    input wr_req_valid, wr_req_addr, wr_req_len, wr_req_size, wr_data_valid, wr_data, wr_strb,
    output rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_last,
    output wr_req_ready, wr_data_ready, wr_done, wr_resp
  );
endinterface

// File: rtl/axi3_nport_bridge_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic found;
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && i >= int'(ptr)) begin
        grant[i] = 1'b1;
        found = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi3_nport_bridge.sv
// axi3_nport_bridge: N read clients plus one write client onto one AXI3 master port.
module axi3_nport_bridge
  import axi3_nport_bridge_pkg::*;
#(
  parameter int N_RD = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 4,
  parameter int WR_ID = 0,
  parameter int LEN_W = 8
) (
  input logic clock,
  input logic reset,
  nport_client_if.slave cl,
  axi3_if.master axi
);
  localparam int PW = N_RD > 1 ? $clog2(N_RD) : 1;
  ar_state_t ar_state, ar_next;
  w_state_t w_state, w_next;
  logic [N_RD-1:0] busy, grant, hit, clr;
  logic [PW-1:0] ptr, ptr_n;
  logic [ID_W-1:0] gid, ar_id;
  logic [ADDR_W-1:0] g_addr, ar_addr, aw_addr;
  logic [LEN_W-1:0] g_len, ar_len, aw_len, cnt;
  logic [2:0] g_size, ar_size, aw_size;
  logic take, w_beat;

  rr_arbiter #(.N(N_RD), .PW(PW)) u_arb (
    .req(cl.rd_req_valid & ~busy),
    .ptr(ptr),
    .grant(grant)
  );

  always_comb begin
    gid = '0;
    ptr_n = '0;
    g_addr = '0;
    g_len = '0;
    g_size = '0;
    hit = '0;
    for (int i = 0; i < N_RD; i++) begin
      hit[i] = axi.rid == ID_W'(i);
      if (grant[i]) begin
        gid = ID_W'(i);
        ptr_n = i == N_RD - 1 ? '0 : PW'(i + 1);
        g_addr = cl.rd_req_addr[i*ADDR_W +: ADDR_W];
        g_len = cl.rd_req_len[i*LEN_W +: LEN_W];
        g_size = cl.rd_req_size[i*3 +: 3];
      end
    end
  end

  assign take = ar_state == AR_IDLE && |grant && !reset;
  assign cl.rd_req_ready = take ? grant : '0;
  always_comb ar_next = ar_state == AR_IDLE ? (|grant ? AR_SEND : AR_IDLE)
                                            : (axi.arready ? AR_IDLE : AR_SEND);

  // Unknown rids are acknowledged so a stray beat cannot wedge the R channel.
  assign cl.rd_resp_valid = axi.rvalid && !reset ? hit : '0;
  assign axi.rready = |hit ? |(hit & cl.rd_resp_ready) : 1'b1;
  assign clr = axi.rvalid && axi.rready && axi.rlast ? hit : '0;
  assign cl.rd_resp_data = axi.rdata[DATA_W-1:0];
  assign cl.rd_resp_last = axi.rlast;

  always_ff @(posedge clock) begin
    if (reset) begin
      ar_state <= AR_IDLE;
      busy <= '0;
      ptr <= '0;
    end else begin
      ar_state <= ar_next;
      busy <= (busy & ~clr) | (take ? grant : '0);
      if (take) begin
        ptr <= ptr_n;
        ar_id <= gid;
        ar_addr <= g_addr;
        ar_len <= g_len;
        ar_size <= g_size;
      end
    end
  end

  assign axi.arvalid = ar_state == AR_SEND;
  assign axi.arid = ar_id;
  assign axi.araddr = ar_addr;
  assign axi.arlen = ar_len;
  assign axi.arsize = ar_size;
  assign axi.arburst = BURST_INCR;
  assign axi.arlock = '0;
  assign axi.arcache = '0;
  assign axi.arprot = '0;

  assign w_beat = axi.wvalid && axi.wready;
  assign cl.wr_req_ready = w_state == W_IDLE && cl.wr_req_valid && !reset;
  always_comb w_next = w_state == W_IDLE ? (cl.wr_req_valid ? W_AW : W_IDLE)
                     : w_state == W_AW   ? (axi.awready ? W_DATA : W_AW)
                     : w_state == W_DATA ? (w_beat && axi.wlast ? W_RESP : W_DATA)
                     : (axi.bvalid ? W_IDLE : W_RESP);

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_next;
      if (cl.wr_req_ready) begin
        aw_addr <= cl.wr_req_addr;
        aw_len <= cl.wr_req_len;
        aw_size <= cl.wr_req_size;
        cnt <= '0;
      end else if (w_beat) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign axi.awvalid = w_state == W_AW;
  assign axi.awid = ID_W'(WR_ID);
  assign axi.awaddr = aw_addr;
  assign axi.awlen = aw_len;
  assign axi.awsize = aw_size;
  assign axi.awburst = BURST_INCR;
  assign axi.awlock = '0;
  assign axi.awcache = '0;
  assign axi.awprot = '0;
  assign axi.wvalid = w_state == W_DATA && cl.wr_data_valid;
  assign cl.wr_data_ready = w_state == W_DATA && axi.wready;
  assign axi.wid = ID_W'(WR_ID);
  assign axi.wdata = cl.wr_data;
  assign axi.wstrb = cl.wr_strb;
  assign axi.wlast = cnt == aw_len;
  assign axi.bready = w_state == W_RESP;
  assign cl.wr_done = axi.bready && axi.bvalid;
  assign cl.wr_resp = cl.wr_done ? axi.bresp : RESP_OKAY;
endmodule

// File: tb/tb_axi3_nport_bridge.sv
// tb_axi3_nport_bridge: directed, table-driven and randomized checks of the bridge.
module tb_axi3_nport_bridge;
  import axi3_nport_bridge_pkg::*;
  localparam int N = 3, AW = 32, DW = 32, IW = 4, LW = 8;
  logic clock = 1'b0, reset = 1'b1;
  int checks = 0, errors = 0;
  always #5 clock = ~clock;

  nport_client_if #(.N_RD(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) cl();
  axi3_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) axi();
  axi3_nport_bridge #(.N_RD(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .WR_ID(0), .LEN_W(LW)) dut (
    .clock(clock), .reset(reset), .cl(cl), .axi(axi));

  typedef struct { logic rvalid; logic [3:0] rid; logic [2:0] rdy; logic [2:0] exp_v; logic exp_r; } rvec_t;
  typedef struct { logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; } rd_t;

  rvec_t tv[7];
  rd_t slq[$];
  rd_t cur, ear;
  bit r_act, ar_pend, wq_act;
  bit outst[N], rq_act[N];
  int rbeat, ptr, wph, wbeat;
  int order[$];
  logic [31:0] rq_addr[N];
  logic [7:0] rq_len[N];
  logic [31:0] w_addr;
  logic [7:0] w_len;
  logic [3:0] w_strb;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic quiet;
    cl.rd_req_valid = '0; cl.rd_req_addr = '0; cl.rd_req_len = '0; cl.rd_req_size = '0;
    cl.rd_resp_ready = '0; cl.wr_req_valid = 0; cl.wr_req_addr = '0; cl.wr_req_len = '0;
    cl.wr_req_size = '0; cl.wr_data_valid = 0; cl.wr_data = '0; cl.wr_strb = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = '0; axi.bresp = '0;
  endtask

  task automatic do_reset;
    reset = 1;
    quiet();
    tick();
    tick();
    reset = 0;
  endtask

  function automatic logic [31:0] wfun(input logic [31:0] a, input int b);
    return a ^ (32'(b) * 32'h01010101);
  endfunction

  initial begin
    tv[0] = '{1'b1, 4'd0, 3'b001, 3'b001, 1'b1};
    tv[1] = '{1'b1, 4'd1, 3'b001, 3'b010, 1'b0};
    tv[2] = '{1'b1, 4'd2, 3'b100, 3'b100, 1'b1};
    tv[3] = '{1'b0, 4'd2, 3'b111, 3'b000, 1'b1};
    tv[4] = '{1'b1, 4'd5, 3'b000, 3'b000, 1'b1};
    tv[5] = '{1'b1, 4'd15, 3'b111, 3'b000, 1'b1};
    tv[6] = '{1'b1, 4'd2, 3'b011, 3'b100, 1'b0};

    do_reset();
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_wr_done", cl.wr_done, 0);
    chk("rst_rd_req_ready", cl.rd_req_ready, 0);
    chk("rst_rd_resp_valid", cl.rd_resp_valid, 0);

    cl.rd_req_valid = 3'b010;
    cl.rd_req_addr[AW +: AW] = 32'h1fc00000;
    cl.rd_req_len[LW +: LW] = 8'd3;
    cl.rd_req_size[3 +: 3] = 3'd2;
    #1 chk("single_grant", cl.rd_req_ready, 3'b010);
    tick();
    cl.rd_req_valid = '0;
    #1;
    chk("single_arvalid", axi.arvalid, 1);
    chk("single_arid", axi.arid, 1);
    chk("single_arlen", axi.arlen, 3);
    chk("single_araddr", axi.araddr, 32'h1fc00000);
    chk("single_arburst", axi.arburst, BURST_INCR);
    chk("single_busy", dut.busy, 3'b010);
    axi.arready = 1;
    tick();
    axi.arready = 0;
    #1 chk("single_ar_done", axi.arvalid, 0);
    for (int b = 0; b < 4; b++) begin
      axi.rvalid = 1; axi.rid = 4'd1; axi.rdata = 32'h100 + 32'(b); axi.rlast = b == 3;
      cl.rd_resp_ready = 3'b010;
      #1;
      chk("single_rvalid", cl.rd_resp_valid, 3'b010);
      chk("single_rready", axi.rready, 1);
      chk("single_rdata", cl.rd_resp_data, 32'h100 + 32'(b));
      chk("single_rlast", cl.rd_resp_last, b == 3);
      tick();
    end
    axi.rvalid = 0; axi.rlast = 0;
    #1 chk("single_busy_clear", dut.busy, 0);

    for (int i = 0; i < 7; i++) begin
      axi.rvalid = tv[i].rvalid; axi.rid = tv[i].rid; cl.rd_resp_ready = tv[i].rdy;
      axi.rdata = 32'ha5000000 + 32'(i);
      #1;
      chk("route_valid", cl.rd_resp_valid, tv[i].exp_v);
      chk("route_rready", axi.rready, tv[i].exp_r);
      chk("route_data", cl.rd_resp_data, 32'ha5000000 + 32'(i));
    end

    do_reset();
    cl.rd_req_valid = 3'b111;
    axi.arready = 1;
    for (int c = 0; c < 20 && order.size() < 3; c++) begin
      logic [N-1:0] r;
      #1;
      r = cl.rd_req_ready;
      if (axi.arvalid) order.push_back(int'(axi.arid));
      tick();
      cl.rd_req_valid = cl.rd_req_valid & ~r;
    end
    axi.arready = 0;
    chk("rr_count", order.size(), 3);
    if (order.size() == 3) for (int k = 0; k < 3; k++) chk("rr_order", order[k], k);
    cl.rd_req_valid = 3'b001;
    for (int c = 0; c < 3; c++) begin
      #1 chk("busy_block", cl.rd_req_ready, 0);
      tick();
    end
    axi.rvalid = 1; axi.rid = 4'd0; axi.rlast = 1; cl.rd_resp_ready = 3'b001;
    #1;
    chk("busy_same_cycle", cl.rd_req_ready, 0);
    chk("busy_route", cl.rd_resp_valid, 3'b001);
    tick();
    axi.rvalid = 0; axi.rlast = 0;
    #1 chk("busy_next_cycle", cl.rd_req_ready, 3'b001);

    do_reset();
    cl.wr_req_valid = 1; cl.wr_req_addr = 32'h80000000; cl.wr_req_len = 8'd1; cl.wr_req_size = 3'd2;
    #1 chk("wr_req_ready", cl.wr_req_ready, 1);
    tick();
    cl.wr_req_valid = 0; cl.wr_data_valid = 1; cl.wr_data = 32'hdead0001; cl.wr_strb = 4'hf;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("aw_wait_awvalid", axi.awvalid, 1);
      chk("aw_wait_wvalid", axi.wvalid, 0);
      tick();
    end
    axi.awready = 1;
    #1;
    chk("aw_hs_awaddr", axi.awaddr, 32'h80000000);
    chk("aw_hs_awlen", axi.awlen, 1);
    chk("aw_hs_wvalid", axi.wvalid, 0);
    tick();
    axi.awready = 0; axi.wready = 1;
    #1;
    chk("w0_wvalid", axi.wvalid, 1);
    chk("w0_wlast", axi.wlast, 0);
    chk("w0_awvalid", axi.awvalid, 0);
    chk("w0_wdata", axi.wdata, 32'hdead0001);
    tick();
    cl.wr_data = 32'hdead0002;
    #1;
    chk("w1_wlast", axi.wlast, 1);
    chk("w1_wdata", axi.wdata, 32'hdead0002);
    chk("w1_wstrb", axi.wstrb, 4'hf);
    tick();
    cl.wr_data_valid = 0; axi.wready = 0;
    #1;
    chk("resp_wvalid", axi.wvalid, 0);
    chk("resp_bready", axi.bready, 1);
    chk("resp_nodone", cl.wr_done, 0);
    axi.bvalid = 1; axi.bresp = RESP_OKAY;
    #1;
    chk("wr_done", cl.wr_done, 1);
    chk("wr_resp", cl.wr_resp, 0);
    tick();
    axi.bvalid = 0;
    #1;
    chk("wr_done_pulse", cl.wr_done, 0);
    chk("bready_off", axi.bready, 0);

    cl.wr_req_valid = 1; axi.awready = 1;
    tick();
    cl.wr_req_valid = 0;
    tick();
    axi.awready = 0; cl.wr_data_valid = 1; axi.wready = 0;
    #1 chk("mid_wvalid", axi.wvalid, 1);
    reset = 1;
    tick();
    chk("mid_rst_wvalid", axi.wvalid, 0);
    chk("mid_rst_awvalid", axi.awvalid, 0);
    chk("mid_rst_state", dut.w_state, W_IDLE);
    chk("mid_rst_busy", dut.busy, 0);
    reset = 0;

    do_reset();
    ptr = 0; ar_pend = 0; r_act = 0; wph = 0; wbeat = 0; wq_act = 0;
    for (int i = 0; i < N; i++) begin outst[i] = 0; rq_act[i] = 0; rq_addr[i] = '0; rq_len[i] = '0; end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!rq_act[i] && $urandom_range(0, 3) == 0) begin
          rq_act[i] = 1; rq_addr[i] = $urandom; rq_len[i] = 8'($urandom_range(0, 3));
        end
        cl.rd_req_valid[i] = rq_act[i];
        cl.rd_req_addr[i*AW +: AW] = rq_addr[i];
        cl.rd_req_len[i*LW +: LW] = rq_len[i];
        cl.rd_req_size[i*3 +: 3] = 3'd2;
        cl.rd_resp_ready[i] = $urandom_range(0, 3) != 0;
      end
      axi.arready = 1'($urandom_range(0, 1));
      if (!r_act && slq.size() > 0 && $urandom_range(0, 1) == 1) begin
        int k;
        k = $urandom_range(0, slq.size() - 1);
        cur = slq[k]; slq.delete(k); r_act = 1; rbeat = 0;
      end
      axi.rvalid = r_act && $urandom_range(0, 2) != 0;
      axi.rid = cur.id; axi.rdata = cur.addr + 32'(rbeat); axi.rlast = rbeat == int'(cur.len);
      if (wph == 0 && !wq_act && $urandom_range(0, 3) == 0) begin
        wq_act = 1; w_addr = $urandom; w_len = 8'($urandom_range(0, 3)); w_strb = 4'($urandom);
      end
      cl.wr_req_valid = wq_act; cl.wr_req_addr = w_addr; cl.wr_req_len = w_len; cl.wr_req_size = 3'd2;
      cl.wr_data_valid = (wph == 1 || wph == 2) && $urandom_range(0, 1) == 1;
      cl.wr_data = wfun(w_addr, wbeat); cl.wr_strb = w_strb;
      axi.awready = 1'($urandom_range(0, 1)); axi.wready = 1'($urandom_range(0, 1));
      axi.bvalid = wph == 3 && $urandom_range(0, 1) == 1;
      axi.bresp = $urandom_range(0, 1) == 1 ? RESP_OKAY : RESP_SLVERR;
      @(negedge clock);
      chk("r_arvalid", axi.arvalid, ar_pend);
      if (ar_pend) begin
        chk("r_no_grant", cl.rd_req_ready, 0);
        if (axi.arready) begin
          chk("r_arid", axi.arid, ear.id);
          chk("r_araddr", axi.araddr, ear.addr);
          chk("r_arlen", axi.arlen, ear.len);
          chk("r_arsize", axi.arsize, ear.size);
          slq.push_back(ear);
          ar_pend = 0;
        end
      end else begin
        logic [N-1:0] ge;
        int g;
        ge = '0; g = -1;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (ptr + k) % N;
          if (g < 0 && cl.rd_req_valid[j] && !outst[j]) g = j;
        end
        if (g >= 0) ge[g] = 1'b1;
        chk("r_grant", cl.rd_req_ready, ge);
        if (g >= 0) begin
          ear = '{4'(g), rq_addr[g], rq_len[g], 3'd2};
          rq_act[g] = 0; outst[g] = 1; ptr = (g + 1) % N; ar_pend = 1;
        end
      end
      if (axi.rvalid) begin
        logic [N-1:0] ev;
        ev = '0; ev[cur.id] = 1'b1;
        chk("r_resp_valid", cl.rd_resp_valid, ev);
        chk("r_rready", axi.rready, cl.rd_resp_ready[cur.id]);
        chk("r_resp_data", cl.rd_resp_data, cur.addr + 32'(rbeat));
        if (axi.rready) begin
          if (axi.rlast) begin outst[cur.id] = 0; r_act = 0; end
          else rbeat++;
        end
      end else chk("r_resp_idle", cl.rd_resp_valid, 0);
      chk("w_awvalid", axi.awvalid, wph == 1);
      chk("w_bready", axi.bready, wph == 3);
      chk("w_wvalid", axi.wvalid, wph == 2 && cl.wr_data_valid);
      chk("w_req_ready", cl.wr_req_ready, wph == 0 && cl.wr_req_valid);
      chk("w_done", cl.wr_done, wph == 3 && axi.bvalid);
      if (wph == 2) chk("w_data_ready", cl.wr_data_ready, axi.wready);
      case (wph)
        0: if (cl.wr_req_valid) begin wph = 1; wbeat = 0; wq_act = 0; end
        1: if (axi.awready) begin
          chk("w_awaddr", axi.awaddr, w_addr);
          chk("w_awlen", axi.awlen, w_len);
          chk("w_awid", axi.awid, 0);
          chk("w_awburst", axi.awburst, BURST_INCR);
          wph = 2;
        end
        2: if (cl.wr_data_valid && axi.wready) begin
          chk("w_wdata", axi.wdata, wfun(w_addr, wbeat));
          chk("w_wstrb", axi.wstrb, w_strb);
          chk("w_wlast", axi.wlast, wbeat == int'(w_len));
          if (wbeat == int'(w_len)) wph = 3;
          else wbeat++;
        end
        default: if (axi.bvalid) begin
          chk("w_resp", cl.wr_resp, axi.bresp);
          wph = 0;
        end
      endcase
      @(posedge clock);
      #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
